// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: drives the reset / sample-rate / enable-streaming
// command sequence through a byte transceiver, checks each response, retries
// on NACK or silence, then assembles 3-byte movement packets.
module ps2_mouse_ctrl #(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_tx_done,
  output logic       o_wr_ps2,
  output logic [7:0] o_cmd,
  output logic       o_ready,
  output logic       o_err,
  output logic [8:0] o_x,
  output logic [8:0] o_y,
  output logic [2:0] o_btn,
  output logic       o_pkt_tick
);

  typedef enum logic [3:0] {
    S_SEND, S_WAIT_TX, S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID,
    S_RUN1, S_RUN2, S_RUN3, S_FAIL
  } state_t;

  // The transceiver shifts LSB-last, so command bytes are presented reversed.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  function automatic logic [7:0] step_byte(input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = 8'hFF;
      2'd1:    b = 8'hF3;
      2'd2:    b = SAMPLE_RATE;
      2'd3:    b = 8'hF4;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_t      r_state, w_state_nx;
  logic [1:0]  r_step, w_step_nx;
  logic [1:0]  r_retry_cnt, w_retry_nx;
  logic [23:0] r_tmo;
  logic [2:0]  r_btn_nx;
  logic        r_xs, r_ys;
  logic [7:0]  r_dx;
  logic        w_retry_req, w_resend_req;
  logic [1:0]  w_retry_inc;
  logic        w_tmo_hit, w_waiting;

  assign w_retry_inc = r_retry_cnt + 2'd1;
  assign w_tmo_hit   = (r_tmo == (TIMEOUT_CYC - 24'd1));
  assign w_waiting   = (r_state == S_WAIT_TX) || (r_state == S_WAIT_ACK) ||
                       (r_state == S_WAIT_BAT) || (r_state == S_WAIT_ID);

  // State, step and retry bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_SEND;
      r_step      <= 2'd0;
      r_retry_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nx;
      r_step      <= w_step_nx;
      r_retry_cnt <= w_retry_nx;
    end
  end

  // Next-state decode: response checking, retry policy, start override.
  always_comb begin
    w_state_nx   = r_state;
    w_step_nx    = r_step;
    w_retry_nx   = r_retry_cnt;
    w_retry_req  = 1'b0;
    w_resend_req = 1'b0;
    case (r_state)
      S_SEND: w_state_nx = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done)      w_state_nx  = S_WAIT_ACK;
        else if (w_tmo_hit) w_retry_req = 1'b1;
        else                w_state_nx  = r_state;
      end
      S_WAIT_ACK: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'hFA) begin
            if (r_step == 2'd0)      w_state_nx = S_WAIT_BAT;
            else if (r_step == 2'd3) w_state_nx = S_RUN1;
            else begin
              w_step_nx  = r_step + 2'd1;
              w_state_nx = S_SEND;
            end
          end else if (i_rx_data == 8'hFE) begin
            w_resend_req = 1'b1;
          end else begin
            w_retry_req = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_retry_req = 1'b1;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_WAIT_BAT: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'hAA) w_state_nx  = S_WAIT_ID;
          else                    w_retry_req = 1'b1;
        end else if (w_tmo_hit) begin
          w_retry_req = 1'b1;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_WAIT_ID: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'h00) begin
            w_step_nx  = 2'd1;
            w_state_nx = S_SEND;
          end else begin
            w_retry_req = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_retry_req = 1'b1;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_RUN1: begin
        if (i_rx_done && i_rx_data[3]) w_state_nx = S_RUN2;
        else                           w_state_nx = r_state;
      end
      S_RUN2: begin
        if (i_rx_done) w_state_nx = S_RUN3;
        else           w_state_nx = r_state;
      end
      S_RUN3: begin
        if (i_rx_done) w_state_nx = S_RUN1;
        else           w_state_nx = r_state;
      end
      S_FAIL:  w_state_nx = S_FAIL;
      default: w_state_nx = S_SEND;
    endcase

    // A NACK resends the same step; any other failure restarts from step 0.
    if (w_retry_req || w_resend_req) begin
      w_retry_nx = w_retry_inc;
      if (w_retry_inc == MAX_RETRY) begin
        w_state_nx = S_FAIL;
      end else begin
        w_state_nx = S_SEND;
        if (w_retry_req) w_step_nx = 2'd0;
        else             w_step_nx = r_step;
      end
    end else begin
      w_retry_nx = r_retry_cnt;
    end

    if (i_start) begin
      w_state_nx = S_SEND;
      w_step_nx  = 2'd0;
      w_retry_nx = 2'd0;
    end else begin
      w_retry_nx = w_retry_nx;
    end
  end

  // Response timeout: counts while waiting, restarts on every state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       r_tmo <= 24'd0;
    else if (w_state_nx != r_state)  r_tmo <= 24'd0;
    else if (w_waiting)              r_tmo <= r_tmo + 24'd1;
    else                             r_tmo <= 24'd0;
  end

  // Registered command strobe/byte and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_ps2 <= 1'b0;
      o_cmd    <= 8'hFF;
      o_ready  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_wr_ps2 <= (r_state == S_SEND) && (w_state_nx == S_WAIT_TX);
      if ((r_state == S_SEND) && (w_state_nx == S_WAIT_TX)) o_cmd <= bit_rev8(step_byte(r_step));
      else                                                  o_cmd <= o_cmd;
      o_ready  <= (w_state_nx == S_RUN1) || (w_state_nx == S_RUN2) || (w_state_nx == S_RUN3);
      o_err    <= (w_state_nx == S_FAIL);
    end
  end

  // Packet assembly: header and X byte are held until the Y byte completes it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_nx   <= 3'd0;
      r_xs       <= 1'b0;
      r_ys       <= 1'b0;
      r_dx       <= 8'd0;
      o_x        <= 9'd0;
      o_y        <= 9'd0;
      o_btn      <= 3'd0;
      o_pkt_tick <= 1'b0;
    end else begin
      o_pkt_tick <= 1'b0;
      if ((r_state == S_RUN1) && (w_state_nx == S_RUN2)) begin
        r_btn_nx <= i_rx_data[2:0];
        r_xs     <= i_rx_data[4];
        r_ys     <= i_rx_data[5];
      end else if ((r_state == S_RUN2) && (w_state_nx == S_RUN3)) begin
        r_dx <= i_rx_data;
      end else if ((r_state == S_RUN3) && (w_state_nx == S_RUN1)) begin
        o_x        <= {r_xs, r_dx};
        o_y        <= {r_ys, i_rx_data};
        o_btn      <= r_btn_nx;
        o_pkt_tick <= 1'b1;
      end else begin
        r_dx <= r_dx;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, resend, timeout/FAIL,
// packet assembly, resync and start handling.
module tb_ps2_mouse_ctrl;

  localparam logic [23:0] TMO = 24'd40;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic       o_wr_ps2, o_ready, o_err, o_pkt_tick;
  logic [7:0] o_cmd;
  logic [8:0] o_x, o_y;
  logic [2:0] o_btn;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int tick_cnt = 0;

  ps2_mouse_ctrl #(.SAMPLE_RATE(8'd100), .TIMEOUT_CYC(TMO), .MAX_RETRY(2'd3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done), .i_tx_done(i_tx_done), .o_wr_ps2(o_wr_ps2),
    .o_cmd(o_cmd), .o_ready(o_ready), .o_err(o_err), .o_x(o_x), .o_y(o_y),
    .o_btn(o_btn), .o_pkt_tick(o_pkt_tick)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_ps2)   wr_cnt   <= wr_cnt + 1;
    if (o_pkt_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tx();
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  // Wait (bounded) for a write strobe, check the byte and the one-cycle width.
  task automatic expect_cmd(input string tag, input logic [7:0] exp, output int waited);
    waited = 0;
    while (!o_wr_ps2 && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    check({tag, "_seen"}, {31'd0, o_wr_ps2}, 32'd1);
    check({tag, "_cmd"}, {24'd0, o_cmd}, {24'd0, exp});
    @(negedge i_clk);
    check({tag, "_one"}, {31'd0, o_wr_ps2}, 32'd0);
  endtask

  // Full init; optionally NACK the first F3 once.
  task automatic run_init(input bit fe_on_f3, output int w0);
    int w;
    expect_cmd("ff", 8'hFF, w0);
    pulse_tx(); rx_byte(8'hFA); rx_byte(8'hAA); rx_byte(8'h00);
    expect_cmd("f3", 8'hCF, w);
    pulse_tx();
    if (fe_on_f3) begin
      rx_byte(8'hFE);
      expect_cmd("f3_again", 8'hCF, w);
      pulse_tx();
    end
    rx_byte(8'hFA);
    expect_cmd("rate", 8'h26, w);
    pulse_tx(); rx_byte(8'hFA);
    expect_cmd("f4", 8'h2F, w);
    pulse_tx();
    check("ready_pre", {31'd0, o_ready}, 32'd0);
    rx_byte(8'hFA);
    check("ready_post", {31'd0, o_ready}, 32'd1);
    check("err_run", {31'd0, o_err}, 32'd0);
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  initial begin
    int w, snap;
    // Reset values
    repeat (3) @(negedge i_clk);
    check("rst_wr", {31'd0, o_wr_ps2}, 32'd0);
    check("rst_cmd", {24'd0, o_cmd}, 32'h0000_00FF);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_xy", {14'd0, o_x, o_y}, 32'd0);
    check("rst_btn_tick", {28'd0, o_btn, o_pkt_tick}, 32'd0);
    i_rst = 1'b0;

    // Clean init
    run_init(1'b0, w);
    check("first_wr_latency", w, 32'd1);
    check("retry_clean", {30'd0, dut.r_retry_cnt}, 32'd0);

    // Packet 29,05,FB
    rx_byte(8'h29); rx_byte(8'h05);
    check("tick_early", {31'd0, o_pkt_tick}, 32'd0);
    rx_byte(8'hFB);
    check("pkt1_tick", {31'd0, o_pkt_tick}, 32'd1);
    check("pkt1_x", {23'd0, o_x}, 32'h005);
    check("pkt1_y", {23'd0, o_y}, 32'h1FB);
    check("pkt1_btn", {29'd0, o_btn}, 32'd1);
    @(negedge i_clk);
    check("pkt1_tick_one", {31'd0, o_pkt_tick}, 32'd0);

    // Packet 3E,80,01 (both signs, buttons 110)
    rx_byte(8'h3E); rx_byte(8'h80);
    check("pkt2_hold_x", {23'd0, o_x}, 32'h005);
    rx_byte(8'h01);
    check("pkt2_x", {23'd0, o_x}, 32'h180);
    check("pkt2_y", {23'd0, o_y}, 32'h101);
    check("pkt2_btn", {29'd0, o_btn}, 32'd6);
    @(negedge i_clk);

    // Resync: leading 05 has bit3 clear and is dropped
    snap = tick_cnt;
    rx_byte(8'h05); rx_byte(8'h29); rx_byte(8'h05); rx_byte(8'hFB);
    @(negedge i_clk);
    check("resync_ticks", tick_cnt - snap, 32'd1);
    check("resync_x", {23'd0, o_x}, 32'h005);
    check("resync_y", {23'd0, o_y}, 32'h1FB);
    check("resync_btn", {29'd0, o_btn}, 32'd1);

    // Start while in RUN2, then init with one NACK on F3
    rx_byte(8'h3E);
    do_start();
    check("st_run_ready", {31'd0, o_ready}, 32'd0);
    check("st_run_x", {23'd0, o_x}, 32'h005);
    check("st_run_btn", {29'd0, o_btn}, 32'd1);
    run_init(1'b1, w);
    check("st_run_ff_latency", w, 32'd1);
    check("retry_resend", {30'd0, dut.r_retry_cnt}, 32'd1);

    // Start from RUN1, then three silent responses -> FAIL
    do_start();
    check("st2_retry_clr", {30'd0, dut.r_retry_cnt}, 32'd0);
    expect_cmd("tmo0", 8'hFF, w);
    pulse_tx();
    expect_cmd("tmo1", 8'hFF, w);
    check("tmo1_latency", w, 32'(TMO) + 32'd1);
    pulse_tx();
    expect_cmd("tmo2", 8'hFF, w);
    pulse_tx();
    snap = wr_cnt;
    repeat (60) @(negedge i_clk);
    check("fail_err", {31'd0, o_err}, 32'd1);
    check("fail_ready", {31'd0, o_ready}, 32'd0);
    check("fail_no_wr", wr_cnt - snap, 32'd0);

    // Start while in FAIL
    do_start();
    check("st_fail_err", {31'd0, o_err}, 32'd0);
    check("st_fail_retry", {30'd0, dut.r_retry_cnt}, 32'd0);
    check("st_fail_y", {23'd0, o_y}, 32'h1FB);
    expect_cmd("st_fail_ff", 8'hFF, w);
    check("st_fail_latency", w, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
